// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage: FSM encoding, reset defaults and
// the redirect-priority encoding used by the target mux.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_e;

    localparam logic [31:0] DEF_RESET_PC = 32'h0040_0000;
    localparam logic [31:0] DEF_NOP_INST = 32'h0000_0000;

    typedef enum logic [1:0] {
        SEL_NONE   = 2'd0,
        SEL_BRANCH = 2'd1,
        SEL_JR     = 2'd2,
        SEL_JUMP   = 2'd3
    } redir_sel_e;

    // Branch outranks jr, which outranks jump.
    function automatic redir_sel_e redir_pick(input logic branch_taken,
                                              input logic jr,
                                              input logic jump);
        if (branch_taken) return SEL_BRANCH;
        if (jr)           return SEL_JR;
        if (jump)         return SEL_JUMP;
        return SEL_NONE;
    endfunction

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Redirect target mux: picks the winning redirect source and word-aligns it.
module next_pc_sel
    import fetch_pkg::*;
(
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jr,
    input  logic [31:0] jr_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic        any_redir,
    output logic [31:0] target
);

    redir_sel_e  sel;
    logic [31:0] raw_target;

    always_comb begin
        sel        = redir_pick(branch_taken, jr, jump);
        raw_target = '0;
        case (sel)
            SEL_BRANCH: raw_target = branch_target;
            SEL_JR:     raw_target = jr_target;
            SEL_JUMP:   raw_target = jump_target;
            default:    raw_target = '0;
        endcase
        target    = align_word(raw_target);
        any_redir = (sel != SEL_NONE);
    end

endmodule

// File: rtl/fetch_pc_ctrl.sv
// MIPS fetch stage: PC/request FSM, one-entry skid buffer for back-pressure,
// and the IF/ID pipeline register.
module fetch_pc_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter logic [31:0] NOP_INST = DEF_NOP_INST
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        id_stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        jr,
    input  logic [31:0] jr_target,
    output logic        if_valid,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    output logic        flush_ifid
);

    fetch_state_e state, state_n;
    logic [31:0]  pc, pc_n;
    logic [31:0]  req_addr, req_addr_n;
    logic [31:0]  skid_inst, skid_pc;
    logic         skid_load, ifid_mem, ifid_skid, ifid_bubble;
    logic         any_redir, redir;
    logic [31:0]  target;

    next_pc_sel u_next_pc_sel (
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jr            (jr),
        .jr_target     (jr_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .any_redir     (any_redir),
        .target        (target)
    );

    // A redirect only counts when the instruction that caused it is live in ID.
    assign redir      = if_valid & ~id_stall & any_redir;
    assign flush_ifid = redir;
    assign imem_req   = (state == FETCH) || (state == DRAIN);
    assign imem_addr  = req_addr;

    always_comb begin
        state_n     = state;
        pc_n        = pc;
        req_addr_n  = req_addr;
        skid_load   = 1'b0;
        ifid_mem    = 1'b0;
        ifid_skid   = 1'b0;
        case (state)
            IDLE: begin
                state_n    = FETCH;
                req_addr_n = pc;
            end
            FETCH: begin
                if (imem_ready) begin
                    if (redir) begin
                        pc_n       = target;
                        req_addr_n = target;
                    end else if (!id_stall) begin
                        ifid_mem   = 1'b1;
                        pc_n       = req_addr + 32'd4;
                        req_addr_n = req_addr + 32'd4;
                    end else begin
                        skid_load = 1'b1;
                        pc_n      = req_addr + 32'd4;
                        state_n   = HOLD;
                    end
                end else if (redir) begin
                    // The outstanding request cannot be withdrawn; wait it out.
                    pc_n    = target;
                    state_n = DRAIN;
                end
            end
            HOLD: begin
                if (redir) begin
                    pc_n       = target;
                    req_addr_n = target;
                    state_n    = FETCH;
                end else if (!id_stall) begin
                    ifid_skid  = 1'b1;
                    req_addr_n = pc;
                    state_n    = FETCH;
                end
            end
            DRAIN: begin
                if (redir) pc_n = target;
                if (imem_ready) begin
                    req_addr_n = pc_n;
                    state_n    = FETCH;
                end
            end
            default: state_n = IDLE;
        endcase
        ifid_bubble = redir | (~id_stall & ~ifid_mem & ~ifid_skid);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            req_addr <= RESET_PC;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            req_addr <= req_addr_n;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            skid_inst <= NOP_INST;
            skid_pc   <= '0;
        end else if (skid_load) begin
            skid_inst <= imem_rdata;
            skid_pc   <= req_addr;
        end
    end

    // IF/ID register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if_valid <= 1'b0;
            if_inst  <= NOP_INST;
            if_pc    <= '0;
        end else if (ifid_bubble) begin
            if_valid <= 1'b0;
            if_inst  <= NOP_INST;
        end else if (ifid_mem) begin
            if_valid <= 1'b1;
            if_inst  <= imem_rdata;
            if_pc    <= req_addr;
        end else if (ifid_skid) begin
            if_valid <= 1'b1;
            if_inst  <= skid_inst;
            if_pc    <= skid_pc;
        end
    end

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed bench for fetch_pc_ctrl; memory returns ~addr as the instruction.
module tb_fetch_pc_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        id_stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        jr;
    logic [31:0] jr_target;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        flush_ifid;

    int tests  = 0;
    int failed = 0;
    int lat    = 0;
    int wcnt;

    always #5 clk = ~clk;

    fetch_pc_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .id_stall      (id_stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .jr            (jr),
        .jr_target     (jr_target),
        .if_valid      (if_valid),
        .if_inst       (if_inst),
        .if_pc         (if_pc),
        .flush_ifid    (flush_ifid)
    );

    assign imem_rdata = ~imem_addr;
    assign imem_ready = imem_req && (wcnt >= lat);

    always @(posedge clk or negedge reset) begin
        if (!reset)                      wcnt <= 0;
        else if (imem_req && !imem_ready) wcnt <= wcnt + 1;
        else                             wcnt <= 0;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        id_stall = 0; branch_taken = 0; jump = 0; jr = 0;
        branch_target = '0; jump_target = '0; jr_target = '0;
    endtask

    task automatic do_reset;
        lat = 0;
        clear_inputs();
        reset = 0;
        tick();
        reset = 1;
        tick();
    endtask

    task automatic test_reset;
        clear_inputs();
        reset = 0;
        tick(); tick();
        tests++; if (imem_req !== 1'b0) begin failed++; $display("FAIL reset_req got %b want 0", imem_req); end
        tests++; if (if_valid !== 1'b0) begin failed++; $display("FAIL reset_valid got %b want 0", if_valid); end
        tests++; if (if_inst !== 32'h0) begin failed++; $display("FAIL reset_inst got %h want 0", if_inst); end
        tests++; if (if_pc !== 32'h0) begin failed++; $display("FAIL reset_pc got %h want 0", if_pc); end
        reset = 1;
        #1;
        tests++; if (imem_req !== 1'b0) begin failed++; $display("FAIL idle_req got %b want 0", imem_req); end
        tick();
        tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0000) begin failed++; $display("FAIL first_fetch got %b/%h want 1/00400000", imem_req, imem_addr); end
        tick();
        tests++; if (if_valid !== 1'b1 || if_pc !== 32'h0040_0000 || if_inst !== 32'hFFBF_FFFF) begin failed++; $display("FAIL ifid0 got %b/%h/%h want 1/00400000/ffbfffff", if_valid, if_pc, if_inst); end
        tests++; if (imem_addr !== 32'h0040_0004) begin failed++; $display("FAIL addr1 got %h want 00400004", imem_addr); end
        tick();
        tests++; if (if_pc !== 32'h0040_0004 || imem_addr !== 32'h0040_0008) begin failed++; $display("FAIL seq2 got %h/%h want 00400004/00400008", if_pc, imem_addr); end
        reset = 0;
        #1;
        tests++; if (imem_req !== 1'b0 || if_valid !== 1'b0) begin failed++; $display("FAIL midreset got %b/%b want 0/0", imem_req, if_valid); end
        tick();
        reset = 1;
        #1;
        tests++; if (imem_req !== 1'b0) begin failed++; $display("FAIL reidle_req got %b want 0", imem_req); end
        tick();
        tests++; if (imem_addr !== 32'h0040_0000 || imem_req !== 1'b1) begin failed++; $display("FAIL refetch got %b/%h want 1/00400000", imem_req, imem_addr); end
    endtask

    task automatic test_branch;
        do_reset();
        tick(); tick(); tick();
        tests++; if (if_pc !== 32'h0040_0008 || imem_addr !== 32'h0040_000C) begin failed++; $display("FAIL br_pre got %h/%h want 00400008/0040000c", if_pc, imem_addr); end
        branch_taken = 1; branch_target = 32'h0040_0020;
        #1;
        tests++; if (flush_ifid !== 1'b1) begin failed++; $display("FAIL br_flush got %b want 1", flush_ifid); end
        tick();
        branch_taken = 0;
        #1;
        tests++; if (flush_ifid !== 1'b0) begin failed++; $display("FAIL br_flush_pulse got %b want 0", flush_ifid); end
        tests++; if (if_valid !== 1'b0 || imem_addr !== 32'h0040_0020) begin failed++; $display("FAIL br_squash got %b/%h want 0/00400020", if_valid, imem_addr); end
        tick();
        tests++; if (if_valid !== 1'b1 || if_pc !== 32'h0040_0020 || if_inst !== 32'hFFBF_FFDF) begin failed++; $display("FAIL br_target got %b/%h/%h want 1/00400020/ffbfffdf", if_valid, if_pc, if_inst); end
    endtask

    task automatic test_drain;
        do_reset();
        tick();
        lat = 3;
        jump = 1; jump_target = 32'h0040_0100;
        #1;
        tests++; if (flush_ifid !== 1'b1 || imem_ready !== 1'b0) begin failed++; $display("FAIL dr_flush got %b/%b want 1/0", flush_ifid, imem_ready); end
        tick();
        jump = 0;
        #1;
        tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0004 || if_valid !== 1'b0) begin failed++; $display("FAIL dr_hold1 got %b/%h/%b want 1/00400004/0", imem_req, imem_addr, if_valid); end
        tick(); tick();
        tests++; if (imem_addr !== 32'h0040_0004 || imem_ready !== 1'b1) begin failed++; $display("FAIL dr_hold3 got %h/%b want 00400004/1", imem_addr, imem_ready); end
        tick();
        tests++; if (imem_addr !== 32'h0040_0100 || if_valid !== 1'b0 || imem_req !== 1'b1) begin failed++; $display("FAIL dr_retarget got %b/%h/%b want 1/00400100/0", imem_req, imem_addr, if_valid); end
        lat = 0;
        tick();
        tests++; if (if_valid !== 1'b1 || if_pc !== 32'h0040_0100) begin failed++; $display("FAIL dr_first got %b/%h want 1/00400100", if_valid, if_pc); end
    endtask

    task automatic test_stall;
        do_reset();
        tick();
        id_stall = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            tests++; if (imem_req !== 1'b0 || if_pc !== 32'h0040_0000 || if_valid !== 1'b1) begin failed++; $display("FAIL st_hold%0d got %b/%h/%b want 0/00400000/1", i, imem_req, if_pc, if_valid); end
        end
        id_stall = 0;
        tick();
        tests++; if (if_pc !== 32'h0040_0004 || if_inst !== 32'hFFBF_FFFB || if_valid !== 1'b1) begin failed++; $display("FAIL st_skid got %b/%h/%h want 1/00400004/ffbffffb", if_valid, if_pc, if_inst); end
        tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0008) begin failed++; $display("FAIL st_resume got %b/%h want 1/00400008", imem_req, imem_addr); end
        tick();
        tests++; if (if_pc !== 32'h0040_0008 || if_valid !== 1'b1) begin failed++; $display("FAIL st_next got %b/%h want 1/00400008", if_valid, if_pc); end
    endtask

    task automatic test_priority;
        do_reset();
        tick();
        id_stall = 1; branch_taken = 1; branch_target = 32'h0040_0040;
        #1;
        tests++; if (flush_ifid !== 1'b0) begin failed++; $display("FAIL pr_stalled_flush got %b want 0", flush_ifid); end
        tick();
        tests++; if (if_pc !== 32'h0040_0000 || if_valid !== 1'b1 || imem_req !== 1'b0) begin failed++; $display("FAIL pr_stalled_hold got %b/%h/%b want 1/00400000/0", if_valid, if_pc, imem_req); end
        id_stall = 0;
        jr = 1; jr_target = 32'h0040_0080;
        jump = 1; jump_target = 32'h0040_00C0;
        #1;
        tests++; if (flush_ifid !== 1'b1) begin failed++; $display("FAIL pr_flush got %b want 1", flush_ifid); end
        tick();
        clear_inputs();
        #1;
        tests++; if (imem_addr !== 32'h0040_0040 || if_valid !== 1'b0) begin failed++; $display("FAIL pr_target got %h/%b want 00400040/0", imem_addr, if_valid); end
        tick();
        tests++; if (if_pc !== 32'h0040_0040 || if_valid !== 1'b1) begin failed++; $display("FAIL pr_ifid got %b/%h want 1/00400040", if_valid, if_pc); end
    endtask

    task automatic test_wrap;
        do_reset();
        tick();
        jr = 1; jr_target = 32'hFFFF_FFFE;
        tick();
        clear_inputs();
        #1;
        tests++; if (imem_addr !== 32'hFFFF_FFFC) begin failed++; $display("FAIL wr_align got %h want fffffffc", imem_addr); end
        tick();
        tests++; if (if_pc !== 32'hFFFF_FFFC || imem_addr !== 32'h0000_0000) begin failed++; $display("FAIL wr_wrap got %h/%h want fffffffc/00000000", if_pc, imem_addr); end
        tick();
        tests++; if (if_pc !== 32'h0000_0000 || if_inst !== 32'hFFFF_FFFF || imem_addr !== 32'h0000_0004) begin failed++; $display("FAIL wr_zero got %h/%h/%h want 00000000/ffffffff/00000004", if_pc, if_inst, imem_addr); end
        jr = 1; jr_target = 32'h0040_0103;
        jump = 1; jump_target = 32'h0040_0200;
        tick();
        clear_inputs();
        #1;
        tests++; if (imem_addr !== 32'h0040_0100) begin failed++; $display("FAIL wr_jr got %h want 00400100", imem_addr); end
        tick();
        tests++; if (if_pc !== 32'h0040_0100 || if_valid !== 1'b1) begin failed++; $display("FAIL wr_jr_ifid got %b/%h want 1/00400100", if_valid, if_pc); end
    endtask

    initial begin
        reset = 0;
        clear_inputs();
        test_reset();
        test_branch();
        test_drain();
        test_stall();
        test_priority();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout reached without finishing");
        $fatal(1);
    end

endmodule
